mmio_fifo_frontend: RTL and testbench

- MMIO decode and response stage that sits directly upstream of the 64-bit data FIFO inside the AFU.
- Consumes flattened CCI-P Rx c0 MMIO requests. Host writes to the FIFO data register become FIFO pushes; host reads of it become FIFO pops.
- Also serves the mandatory DFH/AFU-ID CSRs and a FIFO status CSR.
- Produces registered Tx c2 MMIO read responses and maintains its own occupancy count, plus sticky overflow/underflow flags.

---
 rtl/mmio_fifo_frontend_if.sv | 39 +++
 rtl/mmio_fifo_frontend.sv | 115 +++++++++++
 tb/tb_mmio_fifo_frontend.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_fifo_frontend_if.sv
// rtl/mmio_fifo_frontend_if.sv - MMIO request/response and FIFO-side signal bundle
interface mmio_fifo_frontend_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              mmio_wr_valid;
    logic              mmio_rd_valid;
    logic [15:0]       mmio_addr;
    logic [8:0]        mmio_tid;
    logic [DATA_W-1:0] mmio_wdata;

    logic              rd_rsp_valid;
    logic [8:0]        rd_rsp_tid;
    logic [DATA_W-1:0] rd_rsp_data;

    logic              fifo_push;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;

    // The frontend itself.
    modport slave (
        input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        input  fifo_rdata,
        output rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
        output fifo_push, fifo_wdata, fifo_pop, fifo_count
    );

    // Host plus downstream FIFO: everything the frontend consumes or drives, mirrored.
    modport master (
        output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata,
        output fifo_rdata,
        input  rd_rsp_valid, rd_rsp_tid, rd_rsp_data,
        input  fifo_push, fifo_wdata, fifo_pop, fifo_count
    );
endinterface

// File: rtl/mmio_fifo_frontend.sv
// rtl/mmio_fifo_frontend.sv - MMIO decode, CSR responder and push/pop front end of the AFU data FIFO
module mmio_fifo_frontend #(
    parameter int           DEPTH  = 8,
    parameter int           DATA_W = 64,
    parameter logic [127:0] AFU_ID = 128'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mmio_fifo_frontend_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [15:0] ADDR_DFH    = 16'h0000;
    localparam logic [15:0] ADDR_ID_L   = 16'h0002;
    localparam logic [15:0] ADDR_ID_H   = 16'h0004;
    localparam logic [15:0] ADDR_NXT    = 16'h0006;
    localparam logic [15:0] ADDR_RSVD   = 16'h0008;
    localparam logic [15:0] ADDR_DATA   = 16'h0020;
    localparam logic [15:0] ADDR_STATUS = 16'h0022;

    localparam logic [63:0] DFH_VALUE =
        {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              overflow;
    logic              underflow;

    logic              data_wr;
    logic              data_rd;
    logic              status_clr;
    logic              push;
    logic              pop;
    logic              ovf_evt;
    logic              udf_evt;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_word;

    assign data_wr    = bus.mmio_wr_valid && (bus.mmio_addr == ADDR_DATA);
    assign data_rd    = bus.mmio_rd_valid && (bus.mmio_addr == ADDR_DATA);
    assign status_clr = bus.mmio_wr_valid && (bus.mmio_addr == ADDR_STATUS) && bus.mmio_wdata[0];

    // Strobes are gated by rst_n so nothing reaches the FIFO while held in reset.
    // A pop in the same cycle frees a slot, which is why a full FIFO still accepts a push then.
    assign pop     = rst_n && data_rd && (count != '0);
    assign push    = rst_n && data_wr && ((count != CNT_FULL) || pop);
    assign ovf_evt = data_wr && !push;
    assign udf_evt = data_rd && (count == '0);

    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    always_comb begin
        status_word                = '0;
        status_word[CNT_W+1:0]     = {count, overflow, underflow};
    end

    always_comb begin
        rd_word = '0;
        unique case (bus.mmio_addr)
            ADDR_DFH:    rd_word = DATA_W'(DFH_VALUE);
            ADDR_ID_L:   rd_word = DATA_W'(AFU_ID[63:0]);
            ADDR_ID_H:   rd_word = DATA_W'(AFU_ID[127:64]);
            ADDR_NXT:    rd_word = '0;
            ADDR_RSVD:   rd_word = '0;
            ADDR_DATA:   rd_word = (count != '0) ? bus.fifo_rdata : '0;
            ADDR_STATUS: rd_word = status_word;
            default:     rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count <= count_nxt;
            // A new event takes priority over a clear landing in the same cycle.
            if (ovf_evt)         overflow <= 1'b1;
            else if (status_clr) overflow <= 1'b0;
            if (udf_evt)         underflow <= 1'b1;
            else if (status_clr) underflow <= 1'b0;
        end
    end

    // Response data and tid hold their last value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd_rsp_valid <= 1'b0;
            bus.rd_rsp_tid   <= '0;
            bus.rd_rsp_data  <= '0;
        end else begin
            bus.rd_rsp_valid <= bus.mmio_rd_valid;
            if (bus.mmio_rd_valid) begin
                bus.rd_rsp_tid  <= bus.mmio_tid;
                bus.rd_rsp_data <= rd_word;
            end
        end
    end

    assign bus.fifo_push  = push;
    assign bus.fifo_wdata = push ? bus.mmio_wdata : '0;
    assign bus.fifo_pop   = pop;
    assign bus.fifo_count = count;
endmodule

// File: tb/tb_mmio_fifo_frontend.sv
// tb/tb_mmio_fifo_frontend.sv - table-driven bench with response scoreboard for mmio_fifo_frontend
module tb_mmio_fifo_frontend;
    localparam int DEPTH = 8;
    localparam int DW    = 64;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [8:0]  tid;
        logic [63:0] wdata;
        logic        exp_push;
        logic        exp_pop;
        logic [3:0]  exp_cnt;
        logic [63:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          due;
        logic [8:0]  tid;
        logic [63:0] data;
    } rsp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;
    vec_t tbl[$];
    rsp_t exp_q[$];

    mmio_fifo_frontend_if #(.DEPTH(DEPTH), .DATA_W(DW)) bus ();

    mmio_fifo_frontend #(
        .DEPTH (DEPTH),
        .DATA_W(DW),
        .AFU_ID(128'hAAAAAAAAAAAAAAAA_5555555555555555)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream show-ahead FIFO storage reacting to the frontend's strobes.
    logic [63:0] fmem [DEPTH];
    logic [2:0]  hd;
    logic [2:0]  tl;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hd <= '0;
            tl <= '0;
        end else begin
            if (bus.fifo_push) begin
                fmem[tl] <= bus.fifo_wdata;
                tl       <= tl + 3'd1;
            end
            if (bus.fifo_pop) hd <= hd + 3'd1;
        end
    end
    assign bus.fifo_rdata = fmem[hd];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic rd, input logic [15:0] addr,
                                input logic [8:0] tid, input logic [63:0] wdata,
                                input logic push, input logic pop, input logic [3:0] cnt,
                                input logic [63:0] rdata);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.tid = tid; v.wdata = wdata;
        v.exp_push = push; v.exp_pop = pop; v.exp_cnt = cnt; v.exp_rdata = rdata;
        return v;
    endfunction

    task automatic idle_inputs();
        bus.mmio_wr_valid = 1'b0;
        bus.mmio_rd_valid = 1'b0;
        bus.mmio_addr     = '0;
        bus.mmio_tid      = '0;
        bus.mmio_wdata    = '0;
    endtask

    // Called at posedge+1; drives one request cycle and checks the combinational strobes.
    task automatic step(input vec_t v);
        rsp_t r;
        bus.mmio_wr_valid = v.wr;
        bus.mmio_rd_valid = v.rd;
        bus.mmio_addr     = v.addr;
        bus.mmio_tid      = v.tid;
        bus.mmio_wdata    = v.wdata;
        if (v.rd) begin
            r.due = cyc + 1; r.tid = v.tid; r.data = v.exp_rdata;
            exp_q.push_back(r);
        end
        #3;
        chk($sformatf("push@%h", v.addr), 64'(bus.fifo_push), 64'(v.exp_push));
        chk($sformatf("pop@%h", v.addr), 64'(bus.fifo_pop), 64'(v.exp_pop));
        chk("count", 64'(bus.fifo_count), 64'(v.exp_cnt));
        if (v.exp_push) chk("wdata", bus.fifo_wdata, v.wdata);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    // Scoreboard: each read must answer exactly one cycle later, in order.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
            total++;
            bad++;
            $display("FAIL rsp_missing: got none want tid=%h", exp_q[0].tid);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("rsp_valid", 64'(bus.rd_rsp_valid), 64'd1);
            chk("rsp_tid", 64'(bus.rd_rsp_tid), 64'(exp_q[0].tid));
            chk("rsp_data", bus.rd_rsp_data, exp_q[0].data);
            void'(exp_q.pop_front());
        end else if (bus.rd_rsp_valid) begin
            total++;
            bad++;
            $display("FAIL rsp_unexpected: got tid=%h want no response", bus.rd_rsp_tid);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Basic CSRs
        tbl.push_back(mk(0, 1, 16'h0022, 9'h05, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 1, 16'h0000, 9'h01, 0, 0, 0, 0, 64'h1000_0100_0000_0000));
        tbl.push_back(mk(0, 1, 16'h0002, 9'h02, 0, 0, 0, 0, 64'h5555_5555_5555_5555));
        tbl.push_back(mk(0, 1, 16'h0004, 9'h03, 0, 0, 0, 0, 64'hAAAA_AAAA_AAAA_AAAA));
        tbl.push_back(mk(0, 1, 16'h0030, 9'h04, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 1, 16'h0006, 9'h06, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 1, 16'h0008, 9'h07, 0, 0, 0, 0, 64'h0));
        // Ordering
        tbl.push_back(mk(1, 0, 16'h0020, 0, 64'h11, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0020, 0, 64'h22, 1, 0, 1, 0));
        tbl.push_back(mk(1, 0, 16'h0020, 0, 64'h33, 1, 0, 2, 0));
        tbl.push_back(mk(0, 1, 16'h0022, 9'h10, 0, 0, 0, 3, 64'h0C));
        tbl.push_back(mk(0, 1, 16'h0020, 9'h11, 0, 0, 1, 3, 64'h11));
        tbl.push_back(mk(0, 1, 16'h0020, 9'h12, 0, 0, 1, 2, 64'h22));
        tbl.push_back(mk(0, 1, 16'h0020, 9'h13, 0, 0, 1, 1, 64'h33));
        // Fill to full, one extra write overflows
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(1, 0, 16'h0020, 0, 64'h100 + 64'(i), (i < 8), 0, 4'(i), 0));
        tbl.push_back(mk(0, 1, 16'h0022, 9'h20, 0, 0, 0, 8, 64'h22));
        tbl.push_back(mk(1, 0, 16'h0022, 0, 64'h1, 0, 0, 8, 0));
        tbl.push_back(mk(0, 1, 16'h0022, 9'h21, 0, 0, 0, 8, 64'h20));
        // Full with simultaneous write+read: pop first, push accepted, no overflow
        tbl.push_back(mk(1, 1, 16'h0020, 9'h22, 64'h99, 1, 1, 8, 64'h100));
        tbl.push_back(mk(0, 1, 16'h0022, 9'h23, 0, 0, 0, 8, 64'h20));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0, 1, 16'h0020, 9'h30 + 9'(i), 0, 0, 1, 4'(8 - i),
                             (i < 7) ? 64'h101 + 64'(i) : 64'h99));
        // Underflow and empty simultaneous access
        tbl.push_back(mk(0, 1, 16'h0020, 9'h40, 0, 0, 0, 0, 64'h0));
        tbl.push_back(mk(0, 1, 16'h0022, 9'h41, 0, 0, 0, 0, 64'h01));
        tbl.push_back(mk(1, 1, 16'h0020, 9'h42, 64'h77, 1, 0, 0, 64'h0));
        tbl.push_back(mk(0, 1, 16'h0022, 9'h43, 0, 0, 0, 1, 64'h05));
        tbl.push_back(mk(0, 1, 16'h0020, 9'h44, 0, 0, 1, 1, 64'h77));
        tbl.push_back(mk(1, 0, 16'h0030, 0, 64'h5A, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0022, 9'h45, 0, 0, 0, 0, 64'h01));

        // Outputs held at zero during reset even with requests presented
        repeat (2) @(posedge clk);
        #1;
        bus.mmio_wr_valid = 1'b1;
        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = 16'h0020;
        bus.mmio_wdata    = 64'h5;
        #3;
        chk("rst_push", 64'(bus.fifo_push), 64'd0);
        chk("rst_pop", 64'(bus.fifo_pop), 64'd0);
        chk("rst_wdata", bus.fifo_wdata, 64'd0);
        chk("rst_count", 64'(bus.fifo_count), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rd_rsp_valid), 64'd0);
        chk("rst_rsp_tid", 64'(bus.rd_rsp_tid), 64'd0);
        chk("rst_rsp_data", bus.rd_rsp_data, 64'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // Mid-stream reset with count=5 and a read in flight
        for (int i = 0; i < 5; i++)
            step(mk(1, 0, 16'h0020, 0, 64'h200 + 64'(i), 1, 0, 4'(i), 0));
        bus.mmio_rd_valid = 1'b1;
        bus.mmio_addr     = 16'h0020;
        bus.mmio_tid      = 9'h1AB;
        #1;
        chk("pre_rst_count", 64'(bus.fifo_count), 64'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 64'(bus.fifo_count), 64'd0);
        chk("midrst_pop", 64'(bus.fifo_pop), 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("midrst_rsp_valid", 64'(bus.rd_rsp_valid), 64'd0);
        chk("midrst_rsp_data", bus.rd_rsp_data, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(mk(0, 1, 16'h0022, 9'h07, 0, 0, 0, 0, 64'h0));

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
